// File: rtl/flit_source_pkg.sv
// flit_source_pkg: shared definitions for the flit source and its channel
// partners (flit_sink, rtr_channel_input).
//   clogb        - ceiling log2, used for all index/counter widths
//   src_state_e  - flit source FSM encoding
//   ch_*         - bit offsets of the channel fields, MSB-first layout
//                  {link, valid, vc, head, data}
package flit_source_pkg;

    function automatic int clogb(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } src_state_e;

    // Data occupies [dw-1:0]; the control fields stack above it.
    function automatic int ch_head_pos(input int dw);
        return dw;
    endfunction

    function automatic int ch_vc_lsb(input int dw);
        return dw + 1;
    endfunction

    function automatic int ch_valid_pos(input int dw, input int vw);
        return dw + 1 + vw;
    endfunction

    // Only meaningful when the link-ctrl bit is present.
    function automatic int ch_link_pos(input int dw, input int vw);
        return dw + 2 + vw;
    endfunction

    function automatic int ch_width(input int dw, input int vw, input int lw);
        return dw + 2 + vw + lw;
    endfunction

endpackage

// File: rtl/flit_source_credit_tracker.sv
// flit_source_credit_tracker: per-VC downstream credit counters.
//   clk_i, reset_ni       - clock, async active-low reset
//   send_valid_i/vc_i     - a flit is being committed on this VC (consumes credit)
//   credit_valid_i/vc_i   - downstream returned one credit on this VC
//   credit_avail_ivc_o    - per VC: at least one credit held
//   error_o               - sticky: a credit came back while the counter was full
module flit_source_credit_tracker
    import flit_source_pkg::*;
#(
    parameter  int NUM_VCS = 8,
    parameter  int CREDITS = 8,
    localparam int VCW     = (clogb(NUM_VCS) < 1) ? 1 : clogb(NUM_VCS),
    localparam int CW      = clogb(CREDITS + 1)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               send_valid_i,
    input  logic [VCW-1:0]     send_vc_i,
    input  logic               credit_valid_i,
    input  logic [VCW-1:0]     credit_vc_i,
    output logic [NUM_VCS-1:0] credit_avail_ivc_o,
    output logic               error_o
);

    logic [CW-1:0]      credit_q [NUM_VCS];
    logic [NUM_VCS-1:0] dec, inc, ovf;
    logic               error_q;

    always_comb begin
        dec                = '0;
        inc                = '0;
        ovf                = '0;
        credit_avail_ivc_o = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            dec[v] = send_valid_i   && (send_vc_i   == VCW'(v));
            inc[v] = credit_valid_i && (credit_vc_i == VCW'(v));
            // A return that coincides with a send cancels out and cannot overflow.
            ovf[v] = inc[v] && !dec[v] && (credit_q[v] == CW'(CREDITS));
            credit_avail_ivc_o[v] = (credit_q[v] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CW'(CREDITS);
            error_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (inc[v] && !dec[v] && !ovf[v])
                    credit_q[v] <= credit_q[v] + CW'(1);
                else if (dec[v] && !inc[v])
                    credit_q[v] <= credit_q[v] - CW'(1);
            end
            if (|ovf) error_q <= 1'b1;
        end
    end

    assign error_o = error_q;

endmodule

// File: rtl/flit_source.sv
// flit_source: packet descriptor -> flit serializer driving a router input
// channel, with per-VC credit flow control.
//   clk_i, reset_ni       - clock, async active-low reset
//   pkt_valid_i/ready_o   - descriptor handshake (ready is combinational)
//   pkt_vc_i/route_i/length_i - target VC, route field, payload length - MIN
//   channel_o             - {link, valid, vc, head, data}, registered
//   flow_ctrl_i           - {credit_valid, credit_vc}
//   sent_flits_count_o    - valid flits injected, wraps at 2^32
//   error_o               - sticky credit-overflow flag
module flit_source
    import flit_source_pkg::*;
#(
    parameter  int NUM_VCS            = 8,
    parameter  int BUFFER_SIZE        = 64,
    parameter  int MAX_PAYLOAD_LENGTH = 4,
    parameter  int MIN_PAYLOAD_LENGTH = 1,
    parameter  int ROUTE_INFO_WIDTH   = 14,
    parameter  int ENABLE_LINK_PM     = 1,
    parameter  int FLIT_DATA_WIDTH    = 64,
    localparam int VCW  = (clogb(NUM_VCS) < 1) ? 1 : clogb(NUM_VCS),
    localparam int PLR  = clogb(MAX_PAYLOAD_LENGTH - MIN_PAYLOAD_LENGTH + 1),
    localparam int PLW  = (PLR < 1) ? 1 : PLR,
    localparam int LCW  = (ENABLE_LINK_PM != 0) ? 1 : 0,
    localparam int CHW  = ch_width(FLIT_DATA_WIDTH, VCW, LCW)
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [VCW-1:0]              pkt_vc_i,
    input  logic [ROUTE_INFO_WIDTH-1:0] pkt_route_i,
    input  logic [PLW-1:0]              pkt_length_i,
    output logic [CHW-1:0]              channel_o,
    input  logic [VCW:0]                flow_ctrl_i,
    output logic [31:0]                 sent_flits_count_o,
    output logic                        error_o
);

    localparam int DW  = FLIT_DATA_WIDTH;
    localparam int RWR = clogb(MAX_PAYLOAD_LENGTH + 1);
    localparam int RW  = (RWR < 1) ? 1 : RWR;
    localparam logic [RW-1:0] MIN_R = RW'(MIN_PAYLOAD_LENGTH);

    src_state_e        state_q, state_d;
    logic [VCW-1:0]    vc_q, vc_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [31:0]       cnt_q;
    logic              ch_valid_q, ch_head_q;
    logic [VCW-1:0]    ch_vc_q;
    logic [DW-1:0]     ch_data_q;

    logic              fire, head_d, pkt_ready;
    logic [VCW-1:0]    fire_vc;
    logic [DW-1:0]     data_d;
    logic [NUM_VCS-1:0] credit_avail;

    flit_source_credit_tracker #(
        .NUM_VCS (NUM_VCS),
        .CREDITS (BUFFER_SIZE / NUM_VCS)
    ) u_credit (
        .clk_i              (clk_i),
        .reset_ni           (reset_ni),
        .send_valid_i       (fire),
        .send_vc_i          (fire_vc),
        .credit_valid_i     (flow_ctrl_i[VCW]),
        .credit_vc_i        (flow_ctrl_i[VCW-1:0]),
        .credit_avail_ivc_o (credit_avail),
        .error_o            (error_o)
    );

    always_comb begin
        state_d   = state_q;
        vc_d      = vc_q;
        rem_d     = rem_q;
        fire      = 1'b0;
        fire_vc   = vc_q;
        head_d    = 1'b0;
        data_d    = '0;
        pkt_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pkt_ready = reset_ni && credit_avail[pkt_vc_i];
                if (pkt_valid_i && pkt_ready) begin
                    fire    = 1'b1;
                    fire_vc = pkt_vc_i;
                    vc_d    = pkt_vc_i;
                    rem_d   = RW'(pkt_length_i) + MIN_R;
                    head_d  = 1'b1;
                    data_d[ROUTE_INFO_WIDTH-1:0]     = pkt_route_i;
                    data_d[ROUTE_INFO_WIDTH +: PLW]  = pkt_length_i;
                    // Head-only packets never leave IDLE so the next one can follow.
                    state_d = (rem_d == '0) ? ST_IDLE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (credit_avail[vc_q]) begin
                    fire   = 1'b1;
                    data_d = DW'(cnt_q);
                    rem_d  = rem_q - RW'(1);
                    if (rem_q == RW'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            vc_q       <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            ch_valid_q <= 1'b0;
            ch_head_q  <= 1'b0;
            ch_vc_q    <= '0;
            ch_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            vc_q       <= vc_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_q + (fire ? 32'd1 : 32'd0);
            ch_valid_q <= fire;
            ch_head_q  <= head_d;
            ch_vc_q    <= fire ? fire_vc : '0;
            ch_data_q  <= data_d;
        end
    end

    // Link stays up across credit stalls inside a packet.
    if (ENABLE_LINK_PM != 0) begin : g_link
        assign channel_o = {ch_valid_q | (state_q == ST_SEND), ch_valid_q, ch_vc_q, ch_head_q, ch_data_q};
    end else begin : g_nolink
        assign channel_o = {ch_valid_q, ch_vc_q, ch_head_q, ch_data_q};
    end

    assign pkt_ready_o        = pkt_ready;
    assign sent_flits_count_o = cnt_q;

endmodule

// File: tb/tb_flit_source.sv
module tb_flit_source;

    logic        clk, reset_n;
    logic        pkt_valid, ready;
    logic [2:0]  pkt_vc;
    logic [13:0] pkt_route;
    logic [1:0]  pkt_length;
    logic [69:0] channel;
    logic [3:0]  flow_ctrl;
    logic [31:0] cnt;
    logic        err;

    logic        p0_valid, ready0;
    logic [2:0]  p0_vc;
    logic [13:0] p0_route;
    logic [2:0]  p0_length;
    logic [69:0] ch0;
    logic [3:0]  fc0;
    logic [31:0] cnt0;
    logic        err0;

    int npass = 0;
    int ntot  = 0;

    flit_source dut (
        .clk_i(clk), .reset_ni(reset_n), .pkt_valid_i(pkt_valid), .pkt_ready_o(ready),
        .pkt_vc_i(pkt_vc), .pkt_route_i(pkt_route), .pkt_length_i(pkt_length),
        .channel_o(channel), .flow_ctrl_i(flow_ctrl), .sent_flits_count_o(cnt), .error_o(err)
    );

    flit_source #(.MIN_PAYLOAD_LENGTH(0)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .pkt_valid_i(p0_valid), .pkt_ready_o(ready0),
        .pkt_vc_i(p0_vc), .pkt_route_i(p0_route), .pkt_length_i(p0_length),
        .channel_o(ch0), .flow_ctrl_i(fc0), .sent_flits_count_o(cnt0), .error_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    function automatic logic [69:0] mk(input logic l, input logic v, input logic [2:0] c,
                                       input logic h, input logic [63:0] d);
        return {l, v, c, h, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_cred(input int vc, input int exp);
        chk($sformatf("credit[%0d]", vc), 128'(dut.u_credit.credit_q[vc]), 128'(exp));
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; pkt_valid = 1'b1; pkt_vc = 3'd0; pkt_route = '0; pkt_length = '0;
        flow_ctrl = '0; p0_valid = 1'b0; p0_vc = '0; p0_route = '0; p0_length = '0; fc0 = '0;
        nx(); nx();
        // reset state
        chk("rst_channel", channel, 70'd0);
        chk("rst_count", cnt, 32'd0);
        chk("rst_error", err, 1'b0);
        chk("rst_ready", ready, 1'b0);
        pkt_valid = 1'b0;
        reset_n = 1'b1;
        nx();

        // single packet: vc 3, route 0x1A5, 2 payload flits
        pkt_valid = 1'b1; pkt_vc = 3'd3; pkt_route = 14'h1A5; pkt_length = 2'd1;
        #1 chk("sp_ready", ready, 1'b1);
        nx(); pkt_valid = 1'b0;
        chk("sp_head", channel, mk(1, 1, 3, 1, 64'h41A5));
        #1 chk("sp_ready_send", ready, 1'b0);
        nx(); chk("sp_pl1", channel, mk(1, 1, 3, 0, 64'd1));
        nx(); chk("sp_pl2", channel, mk(1, 1, 3, 0, 64'd2));
        nx(); chk("sp_idle", channel, 70'd0);
        chk_cred(3, 5);
        chk("sp_count", cnt, 32'd3);

        // exhaustion on vc 0: two length-4 packets, 8 credits
        pkt_valid = 1'b1; pkt_vc = 3'd0; pkt_route = 14'h2AB; pkt_length = 2'd3;
        nx(); chk("ex_head1", channel, mk(1, 1, 0, 1, 64'hC2AB));
        for (int k = 0; k < 4; k++) begin
            nx(); chk("ex_pl", channel, mk(1, 1, 0, 0, 64'(4 + k)));
        end
        #1 chk("ex_ready_b2b", ready, 1'b1);
        nx(); pkt_valid = 1'b0;
        chk("ex_head2", channel, mk(1, 1, 0, 1, 64'hC2AB));
        nx(); chk("ex_p2_pl1", channel, mk(1, 1, 0, 0, 64'd9));
        nx(); chk("ex_p2_pl2", channel, mk(1, 1, 0, 0, 64'd10));
        nx(); chk("ex_stall", channel, mk(1, 0, 0, 0, 64'd0));
        chk_cred(0, 0);
        flow_ctrl = 4'b1000;
        nx(); flow_ctrl = '0;
        chk("ex_ret_n1", channel, mk(1, 0, 0, 0, 64'd0));
        nx(); chk("ex_ret_n2", channel, mk(1, 1, 0, 0, 64'd11));
        nx(); chk("ex_stall2", channel, mk(1, 0, 0, 0, 64'd0));
        flow_ctrl = 4'b1000;
        nx(); flow_ctrl = '0;
        nx(); chk("ex_last", channel, mk(1, 1, 0, 0, 64'd12));
        nx(); chk("ex_idle", channel, 70'd0);
        chk("ex_count", cnt, 32'd13);

        // drain two credits from vc 4 so a return there can be seen
        pkt_valid = 1'b1; pkt_vc = 3'd4; pkt_route = '0; pkt_length = 2'd0;
        nx(); pkt_valid = 1'b0;
        nx();
        chk_cred(4, 6);

        // simultaneous send and return on vc 2, then return on vc 4 during vc 2 send
        pkt_valid = 1'b1; pkt_vc = 3'd2; flow_ctrl = 4'b1010;
        nx(); pkt_valid = 1'b0; flow_ctrl = 4'b1100;
        chk_cred(2, 8);
        chk("sim_head", channel, mk(1, 1, 2, 1, 64'd0));
        nx(); flow_ctrl = '0;
        chk_cred(2, 7);
        chk_cred(4, 7);
        chk("sim_pl", channel, mk(1, 1, 2, 0, 64'd16));

        // overflow on vc 5
        chk("ovf_pre", err, 1'b0);
        flow_ctrl = 4'b1101;
        nx(); flow_ctrl = '0;
        chk("ovf_set", err, 1'b1);
        chk_cred(5, 8);
        nx(); nx();
        chk("ovf_sticky", err, 1'b1);
        pkt_valid = 1'b1; pkt_vc = 3'd5; pkt_route = 14'h3; pkt_length = 2'd0;
        nx(); pkt_valid = 1'b0;
        chk("ovf_head", channel, mk(1, 1, 5, 1, 64'd3));
        nx(); chk("ovf_pl", channel, mk(1, 1, 5, 0, 64'd18));
        chk("ovf_sticky2", err, 1'b1);
        nx();
        chk_cred(5, 6);

        // reset mid-packet after head plus one payload
        pkt_valid = 1'b1; pkt_vc = 3'd1; pkt_route = 14'h7; pkt_length = 2'd2;
        nx(); pkt_valid = 1'b0;
        nx(); chk("rm_pl1", channel, mk(1, 1, 1, 0, 64'd20));
        reset_n = 1'b0;
        pkt_valid = 1'b1;
        #1;
        chk("rm_channel", channel, 70'd0);
        chk("rm_count", cnt, 32'd0);
        chk("rm_error", err, 1'b0);
        chk("rm_ready", ready, 1'b0);
        for (int i = 0; i < 8; i++) chk_cred(i, 8);
        pkt_valid = 1'b0;
        nx(); reset_n = 1'b1;
        pkt_valid = 1'b1; pkt_vc = 3'd6; pkt_route = 14'h11; pkt_length = 2'd0;
        nx(); pkt_valid = 1'b0;
        chk("rm_new_head", channel, mk(1, 1, 6, 1, 64'h11));
        chk("rm_new_count", cnt, 32'd1);
        nx();

        // min payload length 0: head-only packets back to back
        p0_valid = 1'b1; p0_vc = 3'd1; p0_route = 14'h5; p0_length = 3'd0;
        #1 chk("m0_ready1", ready0, 1'b1);
        nx(); p0_vc = 3'd2; p0_route = 14'h6;
        chk("m0_head1", ch0, mk(1, 1, 1, 1, 64'h5));
        #1 chk("m0_ready2", ready0, 1'b1);
        nx(); p0_valid = 1'b0;
        chk("m0_head2", ch0, mk(1, 1, 2, 1, 64'h6));
        chk("m0_count", cnt0, 32'd2);
        nx(); chk("m0_idle", ch0, 70'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
